bus_rr_arbiter: RTL
===================

# bus_rr_arbiter

Round-robin scheduler for one shared bus segment of the bus generator/arbiter datapath. It arbitrates among `DRVRS` driver FIFOs with pending packets and pops one packet at a time from the winner. It decodes the destination ID from the packet header and pushes the packet into the destination driver's receive FIFO, or into every other driver's FIFO for the broadcast ID. One packet is in flight at a time; fairness comes from a rotating priority pointer.

## Interface

Parameters:
- `DRVRS`, 4, number of drivers on the bus (2..16)
- `PCKG`, 16, packet width in bits; bits `[PCKG-1:PCKG-8]` are the destination ID, the rest is payload (PCKG ≥ 9)
- `BROD`, 8'hFF, broadcast destination ID

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `pndng`  in  DRVRS  driver i's transmit FIFO is non-empty
- `D_pop`  in  DRVRS×PCKG  head word of each transmit FIFO, valid whenever `pndng[i]`=1
- `pop`  out  DRVRS  one-hot pop strobe to transmit FIFOs
- `full`  in  DRVRS  driver i's receive FIFO is full
- `push`  out  DRVRS  push strobes to receive FIFOs (one-hot, or multi-hot for broadcast)
- `D_push`  out  PCKG  packet broadcast on the bus, qualified by `push`
- `busy`  out  1  a packet is in flight (state ≠ IDLE)
- `grant`  out  $clog2(DRVRS)  index of the current or last source driver
- `err`  out  1  one-cycle pulse when a packet is dropped

## Operation

- FSM states: IDLE, POP, DELIVER.
- **IDLE:** if any `pndng`, pick winner g by searching ptr, ptr+1, … with mod-DRVRS wrap. Register `grant`=g and go to POP. If none is pending, stay in IDLE.
- **POP:** `pop[g]`=1 for exactly this cycle. Capture `D_pop[g]` into the data register at the end of the cycle. Decode dest = data[PCKG-1:PCKG-8].
  - dest == BROD: target mask = all drivers except g.
  - dest < DRVRS and dest ≠ g: target mask = one-hot(dest).
  - Otherwise (out of range, or self-addressed): drop the packet, pulse `err`, set ptr=(g+1) mod DRVRS, return to IDLE.
  - Else go to DELIVER.
- **DELIVER:** if (`full` & mask)==0, assert `push`=mask and `D_push`=data for one cycle, set ptr=(g+1) mod DRVRS, and go to IDLE. Otherwise stall in DELIVER with `push`=0 and data held. Broadcast is all-or-nothing: it waits until every target has room.
- Round-robin guarantee: a continuously pending driver is served within DRVRS grants.
- `pndng` deasserting during POP/DELIVER is ignored; the captured packet is still delivered.
- `D_push` holds the last delivered packet between pushes and is 0 after reset.

## Timing

- All outputs are registered.
- Reset (`reset`=0 at a rising edge): state=IDLE, ptr=0, `pop`=0, `push`=0, `D_push`=0, `busy`=0, `grant`=0, `err`=0.
- Reset mid-operation discards the in-flight packet. Its source FIFO has already been popped if POP had completed; no push occurs.
- Latency with no back-pressure: `pndng` seen at edge N (IDLE) → `pop` high in cycle N+1 → `push` high in cycle N+2 → IDLE in cycle N+3. Maximum throughput is one packet per 3 cycles.
- `busy`=1 in POP and DELIVER, including stall cycles.
- `err` is high in the cycle after POP, concurrent with the return to IDLE; it never coincides with `push`.
- Each stall cycle in DELIVER adds one cycle of latency. There is no timeout.
- `pop` and `push` are never asserted in the same cycle.

## Test plan

- Reset then idle: hold `reset`=0 for 2 cycles with `pndng`=4'b1111 → all outputs 0. Release → `pop`=4'b0001 two cycles later (grant 0 first).
- Unicast: driver 1 sends 16'h0312 with all `full`=0 → `pop`=4'b0010, next cycle `push`=4'b1000 and `D_push`=16'h0312, `grant`=1.
- Round-robin: `pndng`=4'b1111 held, every packet addressed validly → grants 0,1,2,3,0; `pop` spaced exactly 3 cycles apart.
- Broadcast with back-pressure: driver 2 sends 16'hFFAB while `full`=4'b0010 for 4 cycles → `busy` stays 1 and `push`=0 during the stall. Push occurs the cycle after `full` clears with `push`=4'b1011, `D_push`=16'hFFAB.
- Bad destination: driver 0 sends 16'h0711, then driver 3 sends 16'h0355 (self-addressed) → each is popped, `err` pulses once per packet, `push` never asserts, and ptr advances past the source.
- Reset mid-flight: assert `reset`=0 during DELIVER while `full` holds a stall → next cycle state IDLE, `push`=0, `D_push`=0, `busy`=0. After release, arbitration restarts at driver 0.

Source files
------------

// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if
//   Bundles every signal between the round-robin bus arbiter and the driver
//   FIFOs of one bus segment.
//
//   master : the arbiter (drives pop/push/D_push/busy/grant/err/state_dbg)
//   slave  : the FIFO side (drives pndng/D_pop/full)
//
//   Handshake semantics:
//     transmit side: pndng[i] acts as "valid" and D_pop[i] is the head word
//     while pndng[i]=1. pop[i] is a one-cycle "take" strobe; the FIFO
//     advances its head at the rising edge that ends the pop cycle.
//     Receive side: full[i] is an inverted "ready". push[i] is only raised
//     toward a FIFO whose full bit was 0 at the edge that launched the push.
//     D_push is meaningful only while some push bit is 1.
//
//   Signals:
//     pndng     [DRVRS]          transmit FIFO i non-empty
//     D_pop     [DRVRS][PCKG]    head word of each transmit FIFO
//     pop       [DRVRS]          one-hot pop strobe
//     full      [DRVRS]          receive FIFO i full
//     push      [DRVRS]          push strobes (multi-hot for broadcast)
//     D_push    [PCKG]           packet on the bus
//     busy                       a packet is in flight
//     grant     [clog2(DRVRS)]   current or last source driver
//     err                        one-cycle drop pulse
//     state_dbg [2]              arbiter FSM state for observation
interface bus_rr_arbiter_if #(
  parameter int DRVRS = 4,
  parameter int PCKG  = 16
);
  localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  logic [DRVRS-1:0]           pndng;
  logic [DRVRS-1:0][PCKG-1:0] D_pop;
  logic [DRVRS-1:0]           pop;
  logic [DRVRS-1:0]           full;
  logic [DRVRS-1:0]           push;
  logic [PCKG-1:0]            D_push;
  logic                       busy;
  logic [GW-1:0]              grant;
  logic                       err;
  logic [1:0]                 state_dbg;

  modport master (
    input  pndng, D_pop, full,
    output pop, push, D_push, busy, grant, err, state_dbg
  );

  modport slave (
    output pndng, D_pop, full,
    input  pop, push, D_push, busy, grant, err, state_dbg
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Round-robin scheduler for one shared bus segment. Picks one driver with a
//   pending packet, pops it, decodes the destination ID in the top 8 bits,
//   and pushes the packet to the destination receive FIFO, or to every other
//   driver for the broadcast ID. One packet in flight at a time.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-low reset
//     bus    bus_rr_arbiter_if.master (see interface file for signal list)
//
//   All outputs come straight from flops. A push is launched at the edge
//   that closes POP (or a stall cycle), so the cycle showing push is still a
//   DELIVER cycle; the following edge returns to IDLE.
module bus_rr_arbiter #(
  parameter int         DRVRS = 4,
  parameter int         PCKG  = 16,
  parameter logic [7:0] BROD  = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  bus_rr_arbiter_if.master   bus
);
  localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [GW-1:0]    ptr_q, ptr_n;
  logic [GW-1:0]    grant_q, grant_n;
  logic [PCKG-1:0]  data_q, data_n;
  logic [PCKG-1:0]  d_push_q, d_push_n;
  logic [DRVRS-1:0] mask_q, mask_n;
  logic [DRVRS-1:0] pop_q, pop_n;
  logic [DRVRS-1:0] push_q, push_n;
  logic             busy_q;
  logic             err_q, err_n;

  // Winner search: rotate the pending vector so that bit 0 is the driver at
  // ptr, take the lowest set bit, then map the offset back to an index.
  logic [2*DRVRS-1:0] pend_dbl;
  logic [DRVRS-1:0]   pend_rot;
  logic               any_pend;
  logic [GW:0]        win_sum;
  logic [GW-1:0]      win;

  always_comb begin
    pend_dbl = {bus.pndng, bus.pndng} >> ptr_q;
    pend_rot = pend_dbl[DRVRS-1:0];
    any_pend = |bus.pndng;
    win_sum  = '0;
    for (int k = DRVRS - 1; k >= 0; k--) begin
      if (pend_rot[k]) win_sum = (GW+1)'(ptr_q) + (GW+1)'(k);
    end
    if (win_sum >= (GW+1)'(DRVRS)) win_sum = win_sum - (GW+1)'(DRVRS);
    win = win_sum[GW-1:0];
  end

  // Destination decode of the head word of the granted driver. An empty
  // mask means the packet must be dropped (out of range or self-addressed).
  logic [PCKG-1:0]  head;
  logic [7:0]       dest;
  logic [DRVRS-1:0] self_bit;
  logic [DRVRS-1:0] dec_mask;
  logic [GW-1:0]    next_ptr;

  always_comb begin
    head     = bus.D_pop[grant_q];
    dest     = head[PCKG-1:PCKG-8];
    self_bit = DRVRS'(1) << grant_q;
    if (dest == BROD) begin
      dec_mask = ~self_bit;
    end else if ((dest < 8'(DRVRS)) && (dest != 8'(grant_q))) begin
      dec_mask = DRVRS'(1) << dest;
    end else begin
      dec_mask = '0;
    end
    next_ptr = (grant_q == GW'(DRVRS - 1)) ? '0 : grant_q + GW'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n  = state_q;
    ptr_n    = ptr_q;
    grant_n  = grant_q;
    data_n   = data_q;
    mask_n   = mask_q;
    pop_n    = '0;
    push_n   = '0;
    d_push_n = d_push_q;
    err_n    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_pend) begin
          state_n = POP;
          grant_n = win;
          pop_n   = DRVRS'(1) << win;
        end
      end

      POP: begin
        data_n = head;
        if (dec_mask == '0) begin
          err_n   = 1'b1;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end else begin
          mask_n  = dec_mask;
          state_n = DELIVER;
          if ((bus.full & dec_mask) == '0) begin
            push_n   = dec_mask;
            d_push_n = head;
            ptr_n    = next_ptr;
          end
        end
      end

      DELIVER: begin
        // A non-zero push_q means this cycle is the delivery cycle.
        if (push_q != '0) begin
          state_n = IDLE;
        end else if ((bus.full & mask_q) == '0) begin
          push_n   = mask_q;
          d_push_n = data_q;
          ptr_n    = next_ptr;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      pop_q    <= '0;
      push_q   <= '0;
      d_push_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      ptr_q    <= ptr_n;
      grant_q  <= grant_n;
      data_q   <= data_n;
      mask_q   <= mask_n;
      pop_q    <= pop_n;
      push_q   <= push_n;
      d_push_q <= d_push_n;
      busy_q   <= (state_n != IDLE);
      err_q    <= err_n;
    end
  end

  assign bus.pop       = pop_q;
  assign bus.push      = push_q;
  assign bus.D_push    = d_push_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state_q;
endmodule
